// File: rtl/Definitions.sv
// Shared decode definitions: opcode encodings and the load/store FSM state type.
package Definitions;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    kLOD = 4'h0,
    kCPP = 4'h1,
    kCYY = 4'h2,
    kSTR = 4'h3
  } op_t;

  typedef enum logic [1:0] {IDLE, RD, WB} mem_state_t;

endpackage

// File: rtl/data_mem.sv
// Byte-addressed data array: synchronous write, registered read.
// Ports: Clk, Reset (sync, clears only the read register), we/waddr/wdata
// write port, re/raddr read port, rdata registered read data.
module data_mem #(
  parameter int unsigned W = 8,
  parameter int unsigned A = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         we,
  input  logic [A-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic         re,
  input  logic [A-1:0] raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem [2**A];

  // Array contents survive reset.
  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its value until the next read.
  always_ff @(posedge Clk) begin
    if (Reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller with its data memory. Stores complete in one edge;
// loads take accept/RD/WB cycles and return data with a write-back pulse.
// Ports: Clk, Reset (sync, active-high), InstValid, Operation, Addr,
// StoreData in; MemDataOut, LoadWbEn, Stall, Busy out.
module data_mem_ctrl
  import Definitions::*;
#(
  parameter int unsigned W = 8,
  parameter int unsigned A = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            InstValid,
  input  logic [OP_W-1:0] Operation,
  input  logic [W-1:0]    Addr,
  input  logic [W-1:0]    StoreData,
  output logic [W-1:0]    MemDataOut,
  output logic            LoadWbEn,
  output logic            Stall,
  output logic            Busy
);

  mem_state_t   state;
  logic [A-1:0] addr_q;
  logic         idle;
  logic         ld_accept;
  logic         st_accept;

  assign idle      = (state == IDLE);
  assign ld_accept = idle && InstValid && (Operation == kLOD);
  // A store in a reset cycle must not land in the array.
  assign st_accept = idle && InstValid && (Operation == kSTR) && !Reset;

  // Mealy stall in the accept cycle, then held through RD.
  assign Stall = ld_accept || (state == RD);

  // Load FSM; LoadWbEn and Busy are registered alongside the state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      LoadWbEn <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_accept) begin
            addr_q <= Addr[A-1:0];
            state  <= RD;
            Busy   <= 1'b1;
          end
        end
        RD: begin
          state    <= WB;
          LoadWbEn <= 1'b1;
        end
        WB: begin
          // InstValid ignored here so the held load is not re-accepted.
          state    <= IDLE;
          LoadWbEn <= 1'b0;
          Busy     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          LoadWbEn <= 1'b0;
          Busy     <= 1'b0;
        end
      endcase
    end
  end

  data_mem #(
    .W(W),
    .A(A)
  ) u_data_mem (
    .Clk  (Clk),
    .Reset(Reset),
    .we   (st_accept),
    .waddr(Addr[A-1:0]),
    .wdata(StoreData),
    .re   (state == RD),
    .raddr(addr_q),
    .rdata(MemDataOut)
  );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized self-checking bench for data_mem_ctrl. Two instances (A=8 and
// A=4) see identical stimulus; each is compared to an instruction-level model.
module tb_data_mem_ctrl;
  import Definitions::*;

  logic       Clk;
  logic       Reset;
  logic       InstValid;
  logic [3:0] Operation;
  logic [7:0] Addr;
  logic [7:0] StoreData;

  logic [7:0] d8_data, d4_data;
  logic       d8_wb, d4_wb, d8_stall, d4_stall, d8_busy, d4_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: memory contents with known-flags, and the last load result.
  logic [7:0] m8 [256];
  bit         k8 [256];
  logic [7:0] m4 [16];
  bit         k4 [16];
  logic [7:0] last8, last4;
  bit         lk8, lk4;

  data_mem_ctrl #(.W(8), .A(8)) u_dut8 (
    .Clk(Clk), .Reset(Reset), .InstValid(InstValid), .Operation(Operation),
    .Addr(Addr), .StoreData(StoreData), .MemDataOut(d8_data),
    .LoadWbEn(d8_wb), .Stall(d8_stall), .Busy(d8_busy)
  );

  data_mem_ctrl #(.W(8), .A(4)) u_dut4 (
    .Clk(Clk), .Reset(Reset), .InstValid(InstValid), .Operation(Operation),
    .Addr(Addr), .StoreData(StoreData), .MemDataOut(d4_data),
    .LoadWbEn(d4_wb), .Stall(d4_stall), .Busy(d4_busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Flags packed as {Stall, Busy, LoadWbEn}.
  task automatic check_flags(input string tag, input logic [2:0] exp);
    check({tag, "_flags8"}, 8'({d8_stall, d8_busy, d8_wb}), 8'(exp));
    check({tag, "_flags4"}, 8'({d4_stall, d4_busy, d4_wb}), 8'(exp));
  endtask

  task automatic check_data(input string tag);
    if (lk8) check({tag, "_data8"}, d8_data, last8);
    if (lk4) check({tag, "_data4"}, d4_data, last4);
  endtask

  function automatic logic [3:0] non_mem_op();
    logic [3:0] op;
    do op = 4'($urandom_range(0, 15));
    while (op == kLOD || op == kSTR);
    return op;
  endfunction

  task automatic do_idle();
    @(negedge Clk);
    Reset     = 1'b0;
    InstValid = 1'($urandom);
    Operation = non_mem_op();
    Addr      = 8'($urandom);
    StoreData = 8'($urandom);
    #1;
    check_flags("idle", 3'b000);
    check_data("idle");
  endtask

  task automatic do_store(input logic [7:0] a, input logic [7:0] d);
    @(negedge Clk);
    Reset = 1'b0; InstValid = 1'b1; Operation = kSTR; Addr = a; StoreData = d;
    #1;
    check_flags("store", 3'b000);
    check_data("store");
    m8[a] = d;       k8[a] = 1'b1;
    m4[a[3:0]] = d;  k4[a[3:0]] = 1'b1;
  endtask

  // Scramble the presented instruction unless the load is held (both ignored).
  task automatic busy_inputs(input bit hold);
    if (!hold) begin
      InstValid = 1'($urandom);
      Operation = 4'($urandom);
      Addr      = 8'($urandom);
      StoreData = 8'($urandom);
    end
  endtask

  // rst_at: 0 none, 1 reset during RD, 2 reset during WB.
  task automatic do_load(input logic [7:0] a, input bit hold, input int rst_at);
    @(negedge Clk);
    Reset = 1'b0; InstValid = 1'b1; Operation = kLOD; Addr = a;
    StoreData = 8'($urandom);
    #1;
    check_flags("ld_t0", 3'b100);
    check_data("ld_t0");

    @(negedge Clk);
    busy_inputs(hold);
    if (rst_at == 1) begin
      Reset = 1'b1; InstValid = 1'b1; Operation = kSTR; Addr = a;
      StoreData = ~m8[a];
    end
    #1;
    check_flags("ld_t1", 3'b110);
    check_data("ld_t1");

    if (rst_at != 1) begin
      last8 = m8[a];        lk8 = k8[a];
      last4 = m4[a[3:0]];   lk4 = k4[a[3:0]];
      @(negedge Clk);
      busy_inputs(hold);
      if (rst_at == 2) begin
        Reset = 1'b1; InstValid = 1'b1; Operation = kSTR; Addr = a;
        StoreData = ~m8[a];
      end
      #1;
      check_flags("ld_t2", 3'b011);
      check_data("ld_t2");
    end

    if (rst_at != 0) begin
      @(negedge Clk);
      Reset = 1'b0; InstValid = 1'b0; Operation = non_mem_op();
      last8 = 8'h00; lk8 = 1'b1;
      last4 = 8'h00; lk4 = 1'b1;
      #1;
      check_flags("ld_rst", 3'b000);
      check_data("ld_rst");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) k8[i] = 1'b0;
    for (int i = 0; i < 16; i++)  k4[i] = 1'b0;
    last8 = 8'h00; last4 = 8'h00; lk8 = 1'b1; lk4 = 1'b1;

    Reset = 1'b1; InstValid = 1'b1; Operation = kSTR; Addr = 8'h10; StoreData = 8'hEE;
    repeat (3) @(negedge Clk);
    #1;
    check_flags("reset", 3'b000);
    check_data("reset");
    repeat (5) do_idle();

    // Store then load, held valid through WB.
    do_store(8'h10, 8'hA5);
    do_load(8'h10, 1'b1, 0);
    check("a5_value8", d8_data, 8'hA5);
    do_idle();

    // Back-to-back stores at the address extremes, then loads of both.
    do_store(8'h00, 8'h11);
    do_store(8'hFF, 8'h22);
    do_load(8'h00, 1'b0, 0);
    check("lo_value8", d8_data, 8'h11);
    do_load(8'hFF, 1'b0, 0);
    check("hi_value8", d8_data, 8'h22);
    do_idle();

    // Reset during RD abandons the load; contents survive.
    do_store(8'h40, 8'h5C);
    do_load(8'h40, 1'b1, 1);
    do_load(8'h40, 1'b0, 0);
    check("after_rst8", d8_data, 8'h5C);
    do_load(8'h40, 1'b1, 2);

    // Wrap on the A=4 instance.
    do_store(8'h03, 8'h3C);
    do_store(8'h13, 8'h77);
    do_load(8'h03, 1'b0, 0);
    check("wrap4", d4_data, 8'h77);
    check("nowrap8", d8_data, 8'h3C);

    for (int n = 0; n < 300; n++) begin
      int r;
      logic [7:0] a;
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 31)) : 8'($urandom);
      if (r < 4)       do_store(a, 8'($urandom));
      else if (r < 8)  do_load(a, 1'($urandom), 0);
      else if (r == 8) do_idle();
      else             do_load(a, 1'($urandom), $urandom_range(1, 2));
    end
    do_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
